// File: rtl/phoenix_ni_tx_pkg.sv
// Shared definitions for the Phoenix NoC local-port transmitter: flit width
// and the FSM state encoding used by phoenix_ni_tx.
package phoenix_ni_tx_pkg;

  localparam int TAM_FLIT = 8;

  typedef enum logic [2:0] {
    NI_S_IDLE = 3'd0,
    NI_S_HDR  = 3'd1,
    NI_S_SIZE = 3'd2,
    NI_S_PAY  = 3'd3,
    NI_S_DONE = 3'd4
  } niState_e;

endpackage

// File: rtl/phoenix_ni_tx_stats.sv
// Saturating packet and stall counters for the local-port transmitter.
module phoenix_ni_stats (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_pktDone,
  input  logic        i_stall,
  output logic [15:0] o_pkts,
  output logic [15:0] o_stalls
);

  logic [15:0] r_pkts;
  logic [15:0] r_stalls;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pkts   <= '0;
      r_stalls <= '0;
    end else begin
      if (i_pktDone && (r_pkts != 16'hFFFF)) r_pkts <= r_pkts + 16'd1;
      if (i_stall && (r_stalls != 16'hFFFF)) r_stalls <= r_stalls + 16'd1;
    end
  end

  assign o_pkts   = r_pkts;
  assign o_stalls = r_stalls;

endmodule

// File: rtl/phoenix_ni_tx.sv
// Phoenix NoC local-port transmitter: header, size and payload flits under
// credit flow control. Optional statistics block enabled by PHOENIX_NI_STATS_EN.
module phoenix_ni_tx
  import phoenix_ni_tx_pkg::*;
#(
  parameter logic [TAM_FLIT-1:0] address = '0,
  parameter logic [TAM_FLIT-1:0] MAXLEN  = '1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [TAM_FLIT-1:0] req_target,
  input  logic [TAM_FLIT-1:0] req_len,
  input  logic                pl_valid,
  output logic                pl_ready,
  input  logic [TAM_FLIT-1:0] pl_data,
  input  logic                credit_i,
  output logic                tx,
  output logic [TAM_FLIT-1:0] data_out,
  output logic                clock_tx,
  output logic                busy
`ifdef PHOENIX_NI_STATS_EN
  ,
  output logic [15:0]         stat_pkts,
  output logic [15:0]         stat_stalls
`endif
);

  niState_e            r_state;
  logic [TAM_FLIT-1:0] r_target;
  logic [TAM_FLIT-1:0] r_len;
  logic [TAM_FLIT-1:0] r_cnt;
  logic [TAM_FLIT-1:0] r_data;
  logic                r_tx;

  logic                w_load;
  logic                w_reqAccept;
  logic [TAM_FLIT-1:0] w_lenClamped;

  // The output register can take a new flit when empty or when its flit leaves.
  assign w_load       = ~r_tx | credit_i;
  assign w_reqAccept  = req_valid & req_ready;
  assign w_lenClamped = (req_len > MAXLEN) ? MAXLEN : req_len;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= NI_S_IDLE;
      r_target <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_tx     <= 1'b0;
    end else begin
      if (w_load) r_tx <= 1'b0;
      case (r_state)
        NI_S_IDLE: begin
          if (w_reqAccept) begin
            r_target <= req_target;
            r_len    <= w_lenClamped;
            r_state  <= NI_S_HDR;
          end
        end
        NI_S_HDR: begin
          if (w_load) begin
            r_data  <= r_target;
            r_tx    <= 1'b1;
            r_state <= NI_S_SIZE;
          end
        end
        NI_S_SIZE: begin
          if (w_load) begin
            r_data  <= r_len;
            r_tx    <= 1'b1;
            r_cnt   <= r_len;
            r_state <= (r_len == '0) ? NI_S_DONE : NI_S_PAY;
          end
        end
        NI_S_PAY: begin
          // Without a payload word the register simply drains, leaving a bubble.
          if (w_load && pl_valid) begin
            r_data <= pl_data;
            r_tx   <= 1'b1;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == TAM_FLIT'(1)) r_state <= NI_S_DONE;
          end
        end
        NI_S_DONE: begin
          if (w_load) r_state <= NI_S_IDLE;
        end
        default: r_state <= NI_S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == NI_S_IDLE) & ~reset;
  assign pl_ready  = (r_state == NI_S_PAY) & w_load;
  assign busy      = (r_state != NI_S_IDLE) | r_tx;
  assign tx        = r_tx;
  assign data_out  = r_data;
  assign clock_tx  = clock;

`ifdef PHOENIX_NI_STATS_EN
  logic w_pktDone;
  logic w_stall;

  assign w_pktDone = (r_state == NI_S_DONE) & w_load;
  assign w_stall   = r_tx & ~credit_i;

  phoenix_ni_stats u_stats (
    .clock     (clock),
    .reset     (reset),
    .i_pktDone (w_pktDone),
    .i_stall   (w_stall),
    .o_pkts    (stat_pkts),
    .o_stalls  (stat_stalls)
  );
`else
  // Statistics hardware is left out of this build.
`endif

endmodule
